// File: rtl/dct_row_mac_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the DCT row MAC.
package dct_row_mac_pkg;

   localparam int unsigned DCT_N       = 8;
   localparam int unsigned COEF_W      = 8;
   localparam int unsigned SAMPLE_W    = 8;
   localparam int unsigned ACC_W       = 19;
   localparam int unsigned ROM_LATENCY = 2;
   localparam int unsigned ROW_W       = DCT_N * SAMPLE_W;
   localparam int unsigned BIAS_W      = ACC_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   // Round-half-up then arithmetic shift; the extra bit keeps the bias from overflowing.
   function automatic logic signed [ACC_W-1:0] shift_round(
      input logic signed [ACC_W-1:0] sum,
      input int unsigned             shift
   );
      logic signed [BIAS_W-1:0] biased;
      if (shift == 0) return sum;
      biased = BIAS_W'(sum) + (BIAS_W'(1) << (shift - 1));
      return ACC_W'(biased >>> shift);
   endfunction

endpackage

// File: rtl/dct_dot8.sv
// Combinational 8-term signed dot product of packed sample and coefficient rows.
module dct_dot8
   import dct_row_mac_pkg::*;
(
   input  logic        [ROW_W-1:0]        samples,
   input  logic        [DCT_N*COEF_W-1:0] coeffs,
   output logic signed [ACC_W-1:0]        sum
);

   logic signed [SAMPLE_W+COEF_W-1:0] prod [DCT_N];

   for (genvar j = 0; j < DCT_N; j++) begin : g_prod
      logic signed [SAMPLE_W-1:0] s;
      logic signed [COEF_W-1:0]   c;
      assign s       = samples[ROW_W-1-SAMPLE_W*j -: SAMPLE_W];
      assign c       = coeffs[DCT_N*COEF_W-1-COEF_W*j -: COEF_W];
      assign prod[j] = s * c;
   end

   always_comb begin
      sum = '0;
      for (int unsigned j = 0; j < DCT_N; j++) begin
         sum = sum + ACC_W'(prod[j]);
      end
   end

endmodule

// File: rtl/dct_row_mac.sv
// One row of the 2-D DCT: streams coefficient-row pairs from the ROM and emits two results per cycle.
module dct_row_mac
   import dct_row_mac_pkg::*;
#(
   parameter int unsigned OUT_SHIFT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic        [63:0]       in_data,
   output logic        [2:0]        rom_addr1,
   output logic        [2:0]        rom_addr2,
   input  logic        [63:0]       rom_dout1,
   input  logic        [63:0]       rom_dout2,
   output logic                     out_valid,
   output logic        [1:0]        out_pair,
   output logic signed [ACC_W-1:0]  out_y_even,
   output logic signed [ACC_W-1:0]  out_y_odd,
   output logic                     out_last,
   output logic                     busy
);

   localparam int unsigned LAST = ROM_LATENCY - 1;

   state_t                   state, state_nx;
   logic [1:0]               cnt;
   logic [ROW_W-1:0]         samples;
   logic                     issuing;
   logic [ROM_LATENCY-1:0]   vpipe;
   logic [1:0]               ppipe [ROM_LATENCY];
   logic signed [ACC_W-1:0]  sum_even, sum_odd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)     state_nx = ISSUE;
         ISSUE:   if (cnt == 2'd3)  state_nx = DRAIN;
         DRAIN:   if (cnt == 2'd2)  state_nx = IDLE;
         default:                   state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      issuing   = (state == ISSUE);
      rom_addr1 = issuing ? {cnt, 1'b0} : '0;
      rom_addr2 = issuing ? {cnt, 1'b1} : '0;
   end

   // Counter restarts whenever the FSM changes state, so ISSUE and DRAIN both count from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == IDLE || state_nx != state) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samples <= '0;
      end else if (in_valid && in_ready) begin
         samples <= in_data;
      end
   end

   // Valid/pair pipe matches ROM read latency; clearing it on reset masks stale ROM data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
         for (int unsigned i = 0; i < ROM_LATENCY; i++) ppipe[i] <= '0;
      end else begin
         vpipe    <= {vpipe[ROM_LATENCY-2:0], issuing};
         ppipe[0] <= cnt;
         for (int unsigned i = 1; i < ROM_LATENCY; i++) ppipe[i] <= ppipe[i-1];
      end
   end

   dct_dot8 u_dot_even (
      .samples (samples),
      .coeffs  (rom_dout1),
      .sum     (sum_even)
   );

   dct_dot8 u_dot_odd (
      .samples (samples),
      .coeffs  (rom_dout2),
      .sum     (sum_odd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_pair   <= '0;
         out_y_even <= '0;
         out_y_odd  <= '0;
      end else begin
         out_valid <= vpipe[LAST];
         out_last  <= vpipe[LAST] && (ppipe[LAST] == 2'd3);
         if (vpipe[LAST]) begin
            out_pair   <= ppipe[LAST];
            out_y_even <= shift_round(sum_even, OUT_SHIFT);
            out_y_odd  <= shift_round(sum_odd, OUT_SHIFT);
         end
      end
   end

endmodule

// File: tb/tb_dct_row_mac.sv
// Drives a raw-sum and a scaled instance side by side, each with its own 2-cycle coefficient ROM.
module tb_dct_row_mac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;

   logic               in_ready  [2];
   logic               busy      [2];
   logic               out_valid [2];
   logic               out_last  [2];
   logic [1:0]         out_pair  [2];
   logic [2:0]         addr1     [2];
   logic [2:0]         addr2     [2];
   logic [63:0]        rom1_q    [2];
   logic [63:0]        rom2_q    [2];
   logic [63:0]        dout1     [2];
   logic [63:0]        dout2     [2];
   logic signed [18:0] y_e       [2];
   logic signed [18:0] y_o       [2];

   int total = 0;
   int bad   = 0;
   int obs [2][8];

   int coef [8][8] = '{
      '{  91,   91,   91,   91,   91,   91,   91,   91},
      '{ 126,  106,   71,   25,  -25,  -71, -106, -126},
      '{ 118,   49,  -49, -118, -118,  -49,   49,  118},
      '{ 106,  -25, -126,  -71,   71,  126,   25, -106},
      '{  91,  -91,  -91,   91,   91,  -91,  -91,   91},
      '{  71, -126,   25,  106, -106,  -25,  126,  -71},
      '{  49, -118,  118,  -49,  -49,  118, -118,   49},
      '{  25,  -71,  106, -126,  126, -106,   71,  -25}
   };

   always #5 clk = ~clk;

   function automatic logic [63:0] rom_row(input logic [2:0] k);
      logic [63:0] r;
      for (int j = 0; j < 8; j++) r[63-8*j -: 8] = 8'(coef[k][j]);
      return r;
   endfunction

   always_ff @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         rom1_q[d] <= rom_row(addr1[d]);
         rom2_q[d] <= rom_row(addr2[d]);
         dout1[d]  <= rom1_q[d];
         dout2[d]  <= rom2_q[d];
      end
   end

   dct_row_mac #(.OUT_SHIFT(0)) u_raw (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
      .rom_addr1(addr1[0]), .rom_addr2(addr2[0]), .rom_dout1(dout1[0]), .rom_dout2(dout2[0]),
      .out_valid(out_valid[0]), .out_pair(out_pair[0]), .out_y_even(y_e[0]), .out_y_odd(y_o[0]),
      .out_last(out_last[0]), .busy(busy[0])
   );

   dct_row_mac #(.OUT_SHIFT(8)) u_scaled (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
      .rom_addr1(addr1[1]), .rom_addr2(addr2[1]), .rom_dout1(dout1[1]), .rom_dout2(dout2[1]),
      .out_valid(out_valid[1]), .out_pair(out_pair[1]), .out_y_even(y_e[1]), .out_y_odd(y_o[1]),
      .out_last(out_last[1]), .busy(busy[1])
   );

   function automatic int ref_y(input logic [63:0] x, input int k, input int shift);
      int sum = 0;
      logic signed [7:0] s;
      for (int j = 0; j < 8; j++) begin
         s = x[63-8*j -: 8];
         sum += int'(s) * coef[k][j];
      end
      if (shift > 0) sum = (sum + (1 << (shift - 1))) >>> shift;
      return sum;
   endfunction

   function automatic logic [63:0] splat(input logic [7:0] v);
      return {8{v}};
   endfunction

   // Accept one row at the next edge and check every cycle until in_ready returns.
   task automatic run_row(input logic [63:0] x, input bit keep_valid, input string name);
      int p, ea1, ea2, ey_e, ey_o, shift;
      bit ev, er;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (in_ready[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s dut%0d start in_ready got %b want 1", name, d, in_ready[d]);
         end
      end
      in_data  = x;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = keep_valid;
      in_data  = {$urandom(), $urandom()};
      for (int c = 1; c <= 8; c++) begin
         ev  = (c >= 4 && c <= 7);
         er  = (c == 8);
         p   = c - 4;
         ea1 = (c >= 1 && c <= 4) ? 2 * (c - 1) : 0;
         ea2 = (c >= 1 && c <= 4) ? 2 * (c - 1) + 1 : 0;
         for (int d = 0; d < 2; d++) begin
            shift = (d == 0) ? 0 : 8;
            total++;
            if (in_ready[d] !== er || busy[d] !== !er) begin
               bad++;
               $display("FAIL %s dut%0d c%0d ready/busy got %b/%b want %b/%b",
                        name, d, c, in_ready[d], busy[d], er, !er);
            end
            total++;
            if (addr1[d] !== 3'(ea1) || addr2[d] !== 3'(ea2)) begin
               bad++;
               $display("FAIL %s dut%0d c%0d rom_addr got %0d,%0d want %0d,%0d",
                        name, d, c, addr1[d], addr2[d], ea1, ea2);
            end
            total++;
            if (out_valid[d] !== ev || out_last[d] !== (c == 7)) begin
               bad++;
               $display("FAIL %s dut%0d c%0d valid/last got %b/%b want %b/%b",
                        name, d, c, out_valid[d], out_last[d], ev, c == 7);
            end
            if (ev) begin
               ey_e = ref_y(x, 2 * p, shift);
               ey_o = ref_y(x, 2 * p + 1, shift);
               obs[d][2*p]   = int'(y_e[d]);
               obs[d][2*p+1] = int'(y_o[d]);
               total++;
               if (out_pair[d] !== 2'(p) || y_e[d] !== 19'(ey_e) || y_o[d] !== 19'(ey_o)) begin
                  bad++;
                  $display("FAIL %s dut%0d pair got p=%0d y=(%0d,%0d) want p=%0d y=(%0d,%0d)",
                           name, d, out_pair[d], y_e[d], y_o[d], p, ey_e, ey_o);
               end
            end
         end
         if (c < 8) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 || out_pair[d] !== 2'd0 ||
             y_e[d] !== '0 || y_o[d] !== '0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0 ||
             addr1[d] !== 3'd0 || addr2[d] !== 3'd0) begin
            bad++;
            $display("FAIL reset dut%0d got v=%b l=%b p=%0d y=(%0d,%0d) rdy=%b busy=%b a=%0d,%0d want all zero, rdy=1",
                     d, out_valid[d], out_last[d], out_pair[d], y_e[d], y_o[d], in_ready[d], busy[d],
                     addr1[d], addr2[d]);
         end
      end
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_impulse();
      int exp_raw [8] = '{91, 126, 118, 106, 91, 71, 49, 25};
      logic [63:0] x;
      x = 64'h01 << 56;
      run_row(x, 1'b0, "impulse");
      for (int k = 0; k < 8; k++) begin
         total++;
         if (obs[0][k] !== exp_raw[k]) begin
            bad++;
            $display("FAIL impulse_raw y%0d got %0d want %0d", k, obs[0][k], exp_raw[k]);
         end
      end
      total++;
      if (obs[1][0] !== 0) begin
         bad++;
         $display("FAIL impulse_round y0 got %0d want 0", obs[1][0]);
      end
   endtask

   task automatic test_scaled();
      logic [63:0] x;
      run_row(splat(8'd10), 1'b0, "dc10");
      total++;
      if (obs[1][0] !== 28 || obs[1][1] !== 0 || obs[1][7] !== 0) begin
         bad++;
         $display("FAIL dc10_scaled y0,y1,y7 got %0d,%0d,%0d want 28,0,0", obs[1][0], obs[1][1], obs[1][7]);
      end
      x = 64'h02 << 56;
      run_row(x, 1'b0, "x0_2");
      total++;
      if (obs[1][0] !== 1) begin
         bad++;
         $display("FAIL x0_2_scaled y0 got %0d want 1", obs[1][0]);
      end
   endtask

   task automatic test_negative();
      logic [63:0] x;
      run_row(splat(8'h80), 1'b0, "all_neg");
      total++;
      if (obs[0][0] !== -93184 || obs[0][3] !== 0) begin
         bad++;
         $display("FAIL all_neg_raw y0,y3 got %0d,%0d want -93184,0", obs[0][0], obs[0][3]);
      end
      x = 64'h80 << 56;
      run_row(x, 1'b0, "x0_neg");
      total++;
      if (obs[0][1] !== -16128) begin
         bad++;
         $display("FAIL x0_neg_raw y1 got %0d want -16128", obs[0][1]);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) run_row({$urandom(), $urandom()}, 1'b0, "random");
      run_row(splat(8'h7f), 1'b0, "all_max");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 5; r++) run_row({$urandom(), $urandom()}, r < 4, "b2b");
   endtask

   task automatic test_reset_mid_row();
      in_data  = {$urandom(), $urandom()};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (addr1[0] !== 3'd4 || addr2[0] !== 3'd5) begin
         bad++;
         $display("FAIL midrst_pre rom_addr got %0d,%0d want 4,5", addr1[0], addr2[0]);
      end
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         total++;
         if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0 || addr1[d] !== 3'd0 || out_valid[d] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_hold dut%0d got rdy=%b busy=%b a1=%0d v=%b want 1,0,0,0",
                     d, in_ready[d], busy[d], addr1[d], out_valid[d]);
         end
      end
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
         for (int d = 0; d < 2; d++) begin
            total++;
            if (out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
               bad++;
               $display("FAIL midrst_after dut%0d c%0d got v=%b l=%b rdy=%b want 0,0,1",
                        d, c, out_valid[d], out_last[d], in_ready[d]);
            end
         end
         @(posedge clk); #1;
      end
      run_row({$urandom(), $urandom()}, 1'b0, "after_rst");
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_scaled();
      test_negative();
      test_random();
      test_back_to_back();
      test_reset_mid_row();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
